// File: rtl/u_mask_scan_if.sv
// u_mask_scan_if: request/result bundle for u_mask_scan.
//   Request side : i_vld / o_rdy handshake carrying i_x, i_pivot, i_match_bit, i_lsb.
//   Result side  : o_vld / i_rdy handshake carrying o_match, o_idx.
// Signal names are from the block's point of view (i_* flow into the block).
//   slave  modport : the scanning block itself.
//   master modport : the producer/consumer environment driving it.
// W must equal the W of the u_mask_scan instance this bundle connects to.
interface u_mask_scan_if #(
  parameter int W = 64
) ();
  localparam int PW = $clog2(W);

  logic          i_vld;
  logic          o_rdy;
  logic [W-1:0]  i_x;
  logic [PW-1:0] i_pivot;
  logic          i_match_bit;
  logic          i_lsb;
  logic          o_vld;
  logic          i_rdy;
  logic          o_match;
  logic [PW-1:0] o_idx;

  modport slave (
    input  i_vld, i_x, i_pivot, i_match_bit, i_lsb, i_rdy,
    output o_rdy, o_vld, o_match, o_idx
  );

  modport master (
    output i_vld, i_x, i_pivot, i_match_bit, i_lsb, i_rdy,
    input  o_rdy, o_vld, o_match, o_idx
  );
endinterface

// File: rtl/u_mask_scan.sv
// u_mask_scan: multi-cycle pivot-mask matcher.
// Checks that every bit of a W-bit vector on one side of a pivot (pivot
// inclusive) equals a required bit value, scanning C bits per cycle from the
// LSB end, and reports the lowest-index mismatching bit on failure.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - u_mask_scan_if.slave: request (i_vld/o_rdy, i_x, i_pivot,
//          i_match_bit, i_lsb) and result (o_vld/i_rdy, o_match, o_idx)
// Parameters:
//   W          - vector width, multiple of C and >= C
//   C          - bits examined per scan cycle (N = W/C cycles per job)
//   EARLY_EXIT - 1: stop on the first chunk with a mismatch; 0: scan all chunks
module u_mask_scan #(
  parameter int W          = 64,
  parameter int C          = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  u_mask_scan_if.slave bus
);
  localparam int N  = W / C;
  localparam int PW = $clog2(W);
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  x_q, x_d;
  logic [PW-1:0] pivot_q, pivot_d;
  logic          mbit_q, mbit_d;
  logic          lsb_q, lsb_d;
  logic          found_q, found_d;   // a mismatch has already been recorded
  logic [PW-1:0] idx_q, idx_d;       // index of that first mismatch
  logic          match_q, match_d;
  logic [PW-1:0] oidx_q, oidx_d;

  // Per-bit evaluation of the current chunk.
  logic [PW-1:0] base;
  logic [PW-1:0] bit_idx [C];
  logic [C-1:0]  chk;
  logic [C-1:0]  mis;
  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          last_chunk;
  logic          scan_exit;

  assign base = PW'(k_q) * PW'(C);

  for (genvar gi = 0; gi < C; gi++) begin : g_bit
    assign bit_idx[gi] = base + PW'(gi);
    // Unchecked bits never count as a mismatch.
    assign chk[gi] = lsb_q ? (bit_idx[gi] <= pivot_q) : (bit_idx[gi] >= pivot_q);
    assign mis[gi] = chk[gi] & (x_q[bit_idx[gi]] != mbit_q);
  end

  // Lowest set mismatch within the chunk wins: walk from the top down so the
  // last assignment is the lowest index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int j = C - 1; j >= 0; j--) begin
      if (mis[j]) begin
        hit     = 1'b1;
        hit_idx = bit_idx[j];
      end
    end
  end

  assign last_chunk = (k_q == KW'(N - 1));
  assign scan_exit  = last_chunk || ((EARLY_EXIT != 0) && hit);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    pivot_d = pivot_q;
    mbit_d  = mbit_q;
    lsb_d   = lsb_q;
    found_d = found_q;
    idx_d   = idx_q;
    match_d = match_q;
    oidx_d  = oidx_q;

    unique case (state_q)
      IDLE: begin
        if (bus.i_vld) begin
          x_d     = bus.i_x;
          pivot_d = bus.i_pivot;
          mbit_d  = bus.i_match_bit;
          lsb_d   = bus.i_lsb;
          k_d     = '0;
          found_d = 1'b0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Chunks go LSB-first, so the first recorded mismatch is the lowest.
        if (hit && !found_q) begin
          found_d = 1'b1;
          idx_d   = hit_idx;
        end
        if (scan_exit) begin
          match_d = !(found_q || hit);
          oidx_d  = found_q ? idx_q : (hit ? hit_idx : '0);
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (bus.i_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      pivot_q <= '0;
      mbit_q  <= 1'b0;
      lsb_q   <= 1'b0;
      found_q <= 1'b0;
      idx_q   <= '0;
      match_q <= 1'b0;
      oidx_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      pivot_q <= pivot_d;
      mbit_q  <= mbit_d;
      lsb_q   <= lsb_d;
      found_q <= found_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      oidx_q  <= oidx_d;
    end
  end

  assign bus.o_rdy   = (state_q == IDLE);
  assign bus.o_vld   = (state_q == DONE);
  assign bus.o_match = match_q;
  assign bus.o_idx   = oidx_q;
endmodule

// File: tb/tb_u_mask_scan.sv
// Directed bench: two instances (EARLY_EXIT=1 and 0, W=16, C=4) driven with
// identical stimulus; each result and its cycle of arrival is checked.
module tb_u_mask_scan;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  u_mask_scan_if #(.W(W)) bus1 ();
  u_mask_scan_if #(.W(W)) bus0 ();

  u_mask_scan #(.W(W), .C(4), .EARLY_EXIT(1)) dut_ee1 (.clk(clk), .rst(rst), .bus(bus1));
  u_mask_scan #(.W(W), .C(4), .EARLY_EXIT(0)) dut_ee0 (.clk(clk), .rst(rst), .bus(bus0));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] x, input logic [3:0] p,
                       input logic mb, input logic lsb, input logic vld);
    bus1.i_x = x; bus1.i_pivot = p; bus1.i_match_bit = mb; bus1.i_lsb = lsb; bus1.i_vld = vld;
    bus0.i_x = x; bus0.i_pivot = p; bus0.i_match_bit = mb; bus0.i_lsb = lsb; bus0.i_vld = vld;
  endtask

  task automatic set_rdy(input logic r);
    bus1.i_rdy = r;
    bus0.i_rdy = r;
  endtask

  // Present a request in cycle 0 and return just after the accept edge.
  task automatic start_job(input logic [15:0] x, input logic [3:0] p,
                           input logic mb, input logic lsb);
    @(negedge clk);
    drive(x, p, mb, lsb, 1'b1);
    check("rdy_accept_ee1", int'(bus1.o_rdy), 1);
    check("rdy_accept_ee0", int'(bus0.o_rdy), 1);
    @(posedge clk);
  endtask

  // Called right after the accept edge; operands are scrambled once the
  // request is dropped to show they are ignored during the scan.
  task automatic collect(input string tag, input int em, input int eidx,
                         input int ec1, input int ec0);
    int c1 = -1, c0 = -1, n1 = 0, n0 = 0;
    int m1 = -1, m0 = -1, x1 = -1, x0 = -1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      drive(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      if (bus1.o_vld) begin
        n1++;
        if (c1 < 0) begin c1 = cyc; m1 = int'(bus1.o_match); x1 = int'(bus1.o_idx); end
      end
      if (bus0.o_vld) begin
        n0++;
        if (c0 < 0) begin c0 = cyc; m0 = int'(bus0.o_match); x0 = int'(bus0.o_idx); end
      end
      @(posedge clk);
    end
    $display("job %s: ee1 cyc=%0d match=%0d idx=%0d | ee0 cyc=%0d match=%0d idx=%0d",
             tag, c1, m1, x1, c0, m0, x0);
    check({tag, "_cyc_ee1"},   c1, ec1);
    check({tag, "_match_ee1"}, m1, em);
    check({tag, "_idx_ee1"},   x1, eidx);
    check({tag, "_nvld_ee1"},  n1, 1);
    check({tag, "_cyc_ee0"},   c0, ec0);
    check({tag, "_match_ee0"}, m0, em);
    check({tag, "_idx_ee0"},   x0, eidx);
    check({tag, "_nvld_ee0"},  n0, 1);
  endtask

  // Directed vectors: x, pivot, match_bit, lsb -> match, idx, cycle(EE=1), cycle(EE=0)
  localparam int NJ = 9;
  logic [15:0] t_x   [NJ] = '{16'h00F0, 16'h00FF, 16'h01FF, 16'h0100, 16'hFFFE,
                              16'h7FFF, 16'hFFFE, 16'h2100, 16'h0001};
  logic [3:0]  t_p   [NJ] = '{4'd3, 4'd8, 4'd8, 4'd12, 4'd15, 4'd15, 4'd0, 4'd15, 4'd1};
  logic        t_mb  [NJ] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        t_lsb [NJ] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  int          t_m   [NJ] = '{1, 1, 0, 0, 0, 0, 1, 0, 0};
  int          t_idx [NJ] = '{0, 0, 8, 8, 0, 15, 0, 8, 1};
  int          t_c1  [NJ] = '{5, 5, 4, 4, 2, 5, 5, 4, 2};
  int          t_c0  [NJ] = '{5, 5, 5, 5, 5, 5, 5, 5, 5};

  initial begin
    drive(16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    set_rdy(1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy_ee1",   int'(bus1.o_rdy), 1);
    check("rst_vld_ee1",   int'(bus1.o_vld), 0);
    check("rst_match_ee1", int'(bus1.o_match), 0);
    check("rst_idx_ee1",   int'(bus1.o_idx), 0);
    check("rst_rdy_ee0",   int'(bus0.o_rdy), 1);
    check("rst_vld_ee0",   int'(bus0.o_vld), 0);
    rst = 1'b0;

    for (int j = 0; j < NJ; j++) begin
      start_job(t_x[j], t_p[j], t_mb[j], t_lsb[j]);
      collect($sformatf("v%0d", j), t_m[j], t_idx[j], t_c1[j], t_c0[j]);
    end

    // Reset in cycle 2 of a full-length job: it must vanish without a result.
    begin
      int nv = 0;
      start_job(16'h0000, 4'd15, 1'b0, 1'b1);
      @(negedge clk);
      drive(16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_rdy_ee1",   int'(bus1.o_rdy), 1);
      check("mid_rst_vld_ee1",   int'(bus1.o_vld), 0);
      check("mid_rst_match_ee1", int'(bus1.o_match), 0);
      check("mid_rst_idx_ee1",   int'(bus1.o_idx), 0);
      check("mid_rst_rdy_ee0",   int'(bus0.o_rdy), 1);
      check("mid_rst_idx_ee0",   int'(bus0.o_idx), 0);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus1.o_vld || bus0.o_vld) nv++;
      end
      $display("job mid_rst: o_vld cycles after reset=%0d", nv);
      check("mid_rst_no_vld", nv, 0);
    end

    // Backpressure: result held in DONE while a new request waits.
    set_rdy(1'b0);
    start_job(16'h0100, 4'd12, 1'b0, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      drive(16'hFFFE, 4'd15, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_vld_ee1",   int'(bus1.o_vld), 1);
      check("bp_rdy_ee1",   int'(bus1.o_rdy), 0);
      check("bp_match_ee1", int'(bus1.o_match), 0);
      check("bp_idx_ee1",   int'(bus1.o_idx), 8);
      check("bp_vld_ee0",   int'(bus0.o_vld), 1);
      check("bp_rdy_ee0",   int'(bus0.o_rdy), 0);
      check("bp_idx_ee0",   int'(bus0.o_idx), 8);
      if (c == 9) set_rdy(1'b1);
      @(posedge clk);
    end
    $display("job bp_hold: held 10 cycles, idx ee1=%0d ee0=%0d", bus1.o_idx, bus0.o_idx);
    @(negedge clk);
    check("bp_release_rdy_ee1", int'(bus1.o_rdy), 1);
    check("bp_release_rdy_ee0", int'(bus0.o_rdy), 1);
    check("bp_release_vld_ee1", int'(bus1.o_vld), 0);
    @(posedge clk);
    collect("bp_held", 0, 0, 2, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
